// File: rtl/regfile_sb_pkg.sv
// Shared widths, ABI register indices and types for the register file / scoreboard slice.
package regfile_sb_pkg;
    localparam int REGBITS = 5;
    localparam int LOGSIZE = 64;
    localparam int NREGS   = 2 ** REGBITS;
    localparam int CNTBITS = 2;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 2;
    localparam int REG_A0   = 10;
    localparam int REG_A7   = 17;

    typedef logic [REGBITS-1:0] regidx_t;
    typedef logic [LOGSIZE-1:0] xlen_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register in-flight write counters; issue increments, writeback decrements, flush clears.
// Busy is combinational and drops in the cycle the last pending write arrives.
module regfile_scoreboard #(
    parameter int REGBITS = 5,
    parameter int NREGS   = 32,
    parameter int CNTBITS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               iss_en,
    input  logic [REGBITS-1:0] iss_rd,
    input  logic               wr_en,
    input  logic [REGBITS-1:0] wr_addr,
    input  logic [REGBITS-1:0] rs1_addr,
    input  logic [REGBITS-1:0] rs2_addr,
    output logic               iss_ready,
    output logic               rs1_busy,
    output logic               rs2_busy
);
    import regfile_sb_pkg::*;

    localparam logic [CNTBITS-1:0] CNT_MAX = '1;

    logic [CNTBITS-1:0] cnt [NREGS];
    logic               inc;
    logic               dec;
    logic               dec_last;
    logic [NREGS-1:0]   inc_vec;
    logic [NREGS-1:0]   dec_vec;

    assign iss_ready = (iss_rd == REGBITS'(REG_ZERO)) || (cnt[iss_rd] != CNT_MAX);
    assign inc       = iss_en && (iss_rd != REGBITS'(REG_ZERO)) && iss_ready;
    assign dec       = wr_en && (wr_addr != REGBITS'(REG_ZERO)) && (cnt[wr_addr] != '0);
    assign dec_last  = dec && (cnt[wr_addr] == CNTBITS'(1));

    // cnt[0] is never incremented, so x0 can never report busy.
    assign rs1_busy = (cnt[rs1_addr] != '0) && !(dec_last && (wr_addr == rs1_addr));
    assign rs2_busy = (cnt[rs2_addr] != '0) && !(dec_last && (wr_addr == rs2_addr));

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (inc) inc_vec[iss_rd] = 1'b1;
        if (dec) dec_vec[wr_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (inc_vec[i] && !dec_vec[i])
                    cnt[i] <= cnt[i] + CNTBITS'(1);
                else if (dec_vec[i] && !inc_vec[i])
                    cnt[i] <= cnt[i] - CNTBITS'(1);
            end
        end
    end
endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write-through read ports, a0..a7 snapshot and RAW scoreboard.
// Reads are zero-latency; a full per-register counter deasserts iss_ready so issue must hold.
module regfile_sb #(
    parameter int                       REGBITS = 5,
    parameter int                       LOGSIZE = 64,
    parameter int                       NREGS   = 32,
    parameter int                       CNTBITS = 2,
    parameter logic [LOGSIZE-1:0]       SP_INIT = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [REGBITS-1:0]          wr_addr,
    input  logic [LOGSIZE-1:0]          wr_data,
    input  logic [REGBITS-1:0]          rs1_addr,
    input  logic [REGBITS-1:0]          rs2_addr,
    output logic [LOGSIZE-1:0]          rs1_data,
    output logic [LOGSIZE-1:0]          rs2_data,
    input  logic                        iss_en,
    input  logic [REGBITS-1:0]          iss_rd,
    output logic                        iss_ready,
    output logic                        rs1_busy,
    output logic                        rs2_busy,
    input  logic                        flush,
    output logic [7:0][LOGSIZE-1:0]     ecall_reg_val
);
    import regfile_sb_pkg::*;

    logic [LOGSIZE-1:0] regs [NREGS];
    logic               wr_live;

    assign wr_live = wr_en && (wr_addr != REGBITS'(REG_ZERO));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            regs[REG_SP] <= SP_INIT;
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rs1_data = regs[rs1_addr];
        rs2_data = regs[rs2_addr];
        if (rs1_addr == REGBITS'(REG_ZERO))
            rs1_data = '0;
        else if (wr_live && (wr_addr == rs1_addr))
            rs1_data = wr_data;
        if (rs2_addr == REGBITS'(REG_ZERO))
            rs2_data = '0;
        else if (wr_live && (wr_addr == rs2_addr))
            rs2_data = wr_data;
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            if (wr_live && (wr_addr == REGBITS'(REG_A0 + i)))
                ecall_reg_val[i] = wr_data;
            else
                ecall_reg_val[i] = regs[REG_A0 + i];
        end
    end

    regfile_scoreboard #(
        .REGBITS (REGBITS),
        .NREGS   (NREGS),
        .CNTBITS (CNTBITS)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .iss_en    (iss_en),
        .iss_rd    (iss_rd),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .iss_ready (iss_ready),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy)
    );
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus randomized traffic against an array/counter model.
module tb_regfile_sb;
    localparam logic [63:0] SP_VAL = 64'h8000;
    localparam int CMAX = 3;

    logic             clk, rst;
    logic             wr_en, iss_en, flush;
    logic [4:0]       wr_addr, rs1_addr, rs2_addr, iss_rd;
    logic [63:0]      wr_data, rs1_data, rs2_data;
    logic             iss_ready, rs1_busy, rs2_busy;
    logic [7:0][63:0] ecall_reg_val;

    int checks = 0;
    int passes = 0;

    logic [63:0] mregs [32];
    int          mcnt  [32];

    regfile_sb #(.REGBITS(5), .LOGSIZE(64), .NREGS(32), .CNTBITS(2), .SP_INIT(SP_VAL)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .flush(flush), .ecall_reg_val(ecall_reg_val)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = '0;
            mcnt[i]  = 0;
        end
        mregs[2] = SP_VAL;
    endfunction

    function automatic logic [63:0] exp_rd(input logic [4:0] a);
        if (a == 0) return '0;
        if (wr_en && wr_addr == a) return wr_data;
        return mregs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        int pending = mcnt[a];
        if (wr_en && wr_addr == a && pending > 0) pending--;
        return (a != 0) && (pending > 0);
    endfunction

    function automatic logic exp_ready();
        return (iss_rd == 0) || (mcnt[iss_rd] < CMAX);
    endfunction

    function automatic logic [7:0][63:0] exp_ecall();
        logic [7:0][63:0] v;
        for (int i = 0; i < 8; i++) v[i] = exp_rd(5'(10 + i));
        return v;
    endfunction

    // Advance the model with the inputs currently applied, then let the DUT take the edge.
    task automatic tick();
        bit ready, inc, dec;
        ready = exp_ready();
        inc = iss_en && iss_rd != 0 && ready;
        dec = wr_en && wr_addr != 0 && mcnt[wr_addr] > 0;
        if (wr_en && wr_addr != 0) mregs[wr_addr] = wr_data;
        if (flush) begin
            for (int i = 0; i < 32; i++) mcnt[i] = 0;
        end else begin
            if (inc) mcnt[iss_rd]++;
            if (dec) mcnt[wr_addr]--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; iss_en = 0; flush = 0;
        wr_addr = 0; iss_rd = 0; wr_data = '0;
    endtask

    task automatic test_reset();
        rst = 1; idle(); rs1_addr = 0; rs2_addr = 0;
        model_reset();
        #12 rst = 0;
        rs1_addr = 2; iss_rd = 5; #1;
        checks++; if (rs1_data !== SP_VAL) $display("FAIL reset_sp: got %h want %h", rs1_data, SP_VAL); else passes++;
        rs1_addr = 5; #1;
        checks++; if (rs1_data !== 64'h0) $display("FAIL reset_x5: got %h want 0", rs1_data); else passes++;
        checks++; if (rs1_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", rs1_busy); else passes++;
        checks++; if (iss_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", iss_ready); else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_x0();
        wr_en = 1; wr_addr = 0; wr_data = 64'hDEAD; rs1_addr = 0; #1;
        checks++; if (rs1_data !== 64'h0) $display("FAIL x0_same: got %h want 0", rs1_data); else passes++;
        tick();
        idle(); #1;
        checks++; if (rs1_data !== 64'h0) $display("FAIL x0_next: got %h want 0", rs1_data); else passes++;
    endtask

    task automatic test_bypass();
        wr_en = 1; wr_addr = 10; wr_data = 64'h1234; rs1_addr = 10; rs2_addr = 10; #1;
        checks++; if (rs1_data !== 64'h1234) $display("FAIL byp_rs1: got %h want 1234", rs1_data); else passes++;
        checks++; if (rs2_data !== 64'h1234) $display("FAIL byp_rs2: got %h want 1234", rs2_data); else passes++;
        checks++; if (ecall_reg_val[0] !== 64'h1234) $display("FAIL byp_a0: got %h want 1234", ecall_reg_val[0]); else passes++;
        tick();
        idle(); #1;
        checks++; if (rs1_data !== 64'h1234) $display("FAIL stored_rs1: got %h want 1234", rs1_data); else passes++;
        checks++; if (ecall_reg_val[0] !== 64'h1234) $display("FAIL stored_a0: got %h want 1234", ecall_reg_val[0]); else passes++;
    endtask

    task automatic test_saturation();
        iss_en = 1; iss_rd = 7;
        repeat (3) tick();
        #1;
        checks++; if (iss_ready !== 1'b0) $display("FAIL sat_ready: got %b want 0", iss_ready); else passes++;
        tick();
        idle(); rs1_addr = 7;
        for (int k = 0; k < 3; k++) begin
            wr_en = 1; wr_addr = 7; wr_data = 64'(100 + k); #1;
            checks++;
            if (rs1_busy !== (k < 2)) $display("FAIL sat_wb%0d_busy: got %b want %b", k, rs1_busy, (k < 2));
            else passes++;
            tick();
        end
        idle(); iss_rd = 7; #1;
        checks++; if (rs1_busy !== 1'b0) $display("FAIL sat_drained: got %b want 0", rs1_busy); else passes++;
        checks++; if (iss_ready !== 1'b1) $display("FAIL sat_ready_back: got %b want 1", iss_ready); else passes++;
    endtask

    task automatic test_inc_dec_same();
        iss_en = 1; iss_rd = 5; tick();
        wr_en = 1; wr_addr = 5; wr_data = 64'h77; tick();
        idle(); rs1_addr = 5; #1;
        checks++; if (rs1_busy !== 1'b1) $display("FAIL same_busy: got %b want 1", rs1_busy); else passes++;
        checks++; if (rs1_data !== 64'h77) $display("FAIL same_data: got %h want 77", rs1_data); else passes++;
        wr_en = 1; wr_addr = 5; wr_data = 64'h78; #1;
        checks++; if (rs1_busy !== 1'b0) $display("FAIL same_last_wb: got %b want 0", rs1_busy); else passes++;
        tick();
        idle();
    endtask

    task automatic test_flush();
        iss_en = 1; iss_rd = 3; tick();
        iss_rd = 4; tick();
        flush = 1; iss_rd = 9; wr_en = 1; wr_addr = 4; wr_data = 64'hABC; tick();
        idle(); rs1_addr = 9; rs2_addr = 4; #1;
        checks++; if (rs1_busy !== 1'b0) $display("FAIL flush_x9: got %b want 0", rs1_busy); else passes++;
        checks++; if (rs2_busy !== 1'b0) $display("FAIL flush_x4: got %b want 0", rs2_busy); else passes++;
        checks++; if (rs2_data !== 64'hABC) $display("FAIL flush_wdata: got %h want abc", rs2_data); else passes++;
        rs1_addr = 3; rs2_addr = 10; #1;
        checks++; if (rs1_busy !== 1'b0) $display("FAIL flush_x3: got %b want 0", rs1_busy); else passes++;
        checks++; if (rs2_data !== 64'h1234) $display("FAIL flush_keep: got %h want 1234", rs2_data); else passes++;
    endtask

    task automatic test_async_reset();
        wr_en = 1; wr_addr = 3; wr_data = 64'h55; tick();
        idle(); iss_en = 1; iss_rd = 3; tick(); tick();
        idle(); rs1_addr = 3; rs2_addr = 2; #1;
        checks++; if (rs1_busy !== 1'b1 || rs1_data !== 64'h55) $display("FAIL pre_rst: got %b/%h want 1/55", rs1_busy, rs1_data); else passes++;
        #1 rst = 1; model_reset(); #1;
        checks++; if (rs1_data !== 64'h0) $display("FAIL arst_data: got %h want 0", rs1_data); else passes++;
        checks++; if (rs1_busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", rs1_busy); else passes++;
        checks++; if (rs2_data !== SP_VAL) $display("FAIL arst_sp: got %h want %h", rs2_data, SP_VAL); else passes++;
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            iss_en   = ($urandom_range(0, 99) < 45);
            iss_rd   = 5'($urandom_range(0, 12));
            wr_en    = ($urandom_range(0, 99) < 50);
            wr_addr  = 5'($urandom_range(0, 12));
            wr_data  = {$urandom, $urandom};
            flush    = ($urandom_range(0, 99) < 4);
            rs1_addr = 5'($urandom_range(0, 17));
            rs2_addr = 5'($urandom_range(8, 17));
            #1;
            checks++; if (rs1_data !== exp_rd(rs1_addr)) $display("FAIL rnd%0d_rs1: got %h want %h", n, rs1_data, exp_rd(rs1_addr)); else passes++;
            checks++; if (rs2_data !== exp_rd(rs2_addr)) $display("FAIL rnd%0d_rs2: got %h want %h", n, rs2_data, exp_rd(rs2_addr)); else passes++;
            checks++; if (rs1_busy !== exp_busy(rs1_addr)) $display("FAIL rnd%0d_b1: got %b want %b", n, rs1_busy, exp_busy(rs1_addr)); else passes++;
            checks++; if (rs2_busy !== exp_busy(rs2_addr)) $display("FAIL rnd%0d_b2: got %b want %b", n, rs2_busy, exp_busy(rs2_addr)); else passes++;
            checks++; if (iss_ready !== exp_ready()) $display("FAIL rnd%0d_rdy: got %b want %b", n, iss_ready, exp_ready()); else passes++;
            checks++; if (ecall_reg_val !== exp_ecall()) $display("FAIL rnd%0d_ecall: got %h want %h", n, ecall_reg_val, exp_ecall()); else passes++;
            tick();
        end
        idle();
    endtask

    initial begin
        clk = 0;
        test_reset();
        test_x0();
        test_bypass();
        test_saturation();
        test_inc_dec_same();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
